// File: rtl/mmio_pkg.sv
// Shared address map, status-register layout and region decode for the MMIO responder.
package mmio_pkg;

    localparam logic [31:0] RAM_TOP   = 32'h0FF;
    localparam logic [31:0] TX_DATA   = 32'h100;
    localparam logic [31:0] TX_STATUS = 32'h104;
    localparam logic [31:0] TIMER     = 32'h108;
    localparam logic [31:0] GPO       = 32'h10C;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TXD,
        SEL_TXS,
        SEL_TMR,
        SEL_GPO,
        SEL_NONE
    } sel_e;

    // Decode is on the word address, so the two byte-offset bits never matter.
    function automatic sel_e decode(input logic [31:0] addr);
        sel_e sel;
        sel = SEL_NONE;
        if (addr[31:2] <= RAM_TOP[31:2])        sel = SEL_RAM;
        else if (addr[31:2] == TX_DATA[31:2])   sel = SEL_TXD;
        else if (addr[31:2] == TX_STATUS[31:2]) sel = SEL_TXS;
        else if (addr[31:2] == TIMER[31:2])     sel = SEL_TMR;
        else if (addr[31:2] == GPO[31:2])       sel = SEL_GPO;
        return sel;
    endfunction

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Generic circular-buffer FIFO; zero read latency (dout is the head word).
// A push when full is accepted only if a pop happens in the same cycle, else it pulses overflow.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign dout     = mem_q[head_q];
    assign count    = count_q;

    // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop)  head_d = head_q + PW'(1);
        if (do_push) tail_d = tail_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[tail_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// Processor data-port responder: scratch RAM, TX FIFO, cycle timer, GPO; reads combinational.
// Writes land on the clock edge; TX side is valid/ready and never stalls the core (overflow is flagged).
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RAM_WORDS  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] gpo,
    output logic        bus_err
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int RIW = $clog2(RAM_WORDS);

    sel_e            sel;
    logic [31:0]     ram_q [RAM_WORDS];
    logic [RIW-1:0]  ram_idx;
    logic [31:0]     timer_q, timer_d, gpo_q, gpo_d, status;
    logic            ovf_q, ovf_d, berr_q, berr_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty, fifo_ovf, fifo_push, fifo_pop;
    logic            unused_bits;

    assign sel         = decode(a);
    assign ram_idx     = a[2 +: RIW];
    assign unused_bits = ^a[1:0];
    assign fifo_push   = we && (sel == SEL_TXD);
    assign fifo_pop    = tx_valid && tx_ready;
    assign tx_valid    = !fifo_empty;
    assign gpo         = gpo_q;
    assign bus_err     = berr_q;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (wd),
        .dout     (tx_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    always_comb begin
        status                   = '0;
        status[ST_EMPTY]         = fifo_empty;
        status[ST_FULL]          = fifo_full;
        status[ST_OVF]           = ovf_q;
        status[ST_CNT_LSB +: CW] = fifo_count;
        case (sel)
            SEL_RAM: rd = ram_q[ram_idx];
            SEL_TXS: rd = status;
            SEL_TMR: rd = timer_q;
            SEL_GPO: rd = gpo_q;
            default: rd = '0;
        endcase
    end

    // A rejected push in the same cycle as a W1C leaves overflow set.
    always_comb begin
        timer_d = timer_q + 32'd1;
        gpo_d   = gpo_q;
        ovf_d   = ovf_q;
        berr_d  = berr_q;
        if (we && sel == SEL_TMR)                timer_d = wd;
        if (we && sel == SEL_GPO)                gpo_d   = wd;
        if (we && sel == SEL_TXS && wd[ST_OVF])  ovf_d   = 1'b0;
        if (fifo_ovf)                            ovf_d   = 1'b1;
        if (we && sel == SEL_NONE)               berr_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            gpo_q   <= '0;
            ovf_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            gpo_q   <= gpo_d;
            ovf_q   <= ovf_d;
            berr_q  <= berr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we && sel == SEL_RAM) ram_q[ram_idx] <= wd;
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench: stimulus queues expected read data and TX words; a negedge monitor compares them.
module tb_mmio_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd, tx_data, gpo;
    logic        tx_valid, bus_err;
    logic        tx_ready = 1'b0;
    logic        chk_vld = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd [$];
    string       exp_nm [$];
    logic [31:0] exp_tx [$];

    always #5 clk = ~clk;

    mmio_responder dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .gpo      (gpo),
        .bus_err  (bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares rd when a read is flagged and every accepted TX word.
    initial begin
        logic [31:0] e;
        string n;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_underflow: got %h expected none", rd);
                end else begin
                    e = exp_rd.pop_front();
                    n = exp_nm.pop_front();
                    check(n, rd, e);
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_underflow: got %h expected none", tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_data", tx_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rdq(input logic [31:0] addr, input logic [31:0] exp, input string name);
        we = 1'b0; a = addr;
        exp_rd.push_back(exp);
        exp_nm.push_back(name);
        chk_vld = 1'b1;
        @(posedge clk); #1;
        chk_vld = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rdq(32'h108, 32'h0, "timer_after_reset");
        check("tx_valid_reset", {31'b0, tx_valid}, 32'h0);
        check("bus_err_reset", {31'b0, bus_err}, 32'h0);
        check("gpo_reset", gpo, 32'h0);
        rdq(32'h104, 32'h1, "status_reset");

        wr(32'h64, 32'd7);
        wr(32'h60, 32'd3);
        rdq(32'h64, 32'd7, "ram_64");
        rdq(32'h60, 32'd3, "ram_60");
        wr(32'h10C, 32'h5A5A);
        rdq(32'h10C, 32'h5A5A, "gpo_read");

        // Fill past capacity: ninth word is dropped and flags overflow.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_tx.push_back(32'hA0 + 32'(i));
            wr(32'h100, 32'hA0 + 32'(i));
        end
        rdq(32'h104, 32'h806, "status_full_ovf");
        rdq(32'h100, 32'h0, "txdata_reads_zero");
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("tx_drain1", 32'(exp_tx.size()), 32'h0);
        rdq(32'h104, 32'h5, "status_empty_ovf");
        tx_ready = 1'b0;
        wr(32'h104, 32'h4);
        rdq(32'h104, 32'h1, "status_ovf_cleared");

        // Full FIFO plus push-with-pop: accepted, count unchanged.
        for (int i = 0; i < 8; i++) begin
            exp_tx.push_back(32'hC0 + 32'(i));
            wr(32'h100, 32'hC0 + 32'(i));
        end
        exp_tx.push_back(32'hB0);
        tx_ready = 1'b1;
        wr(32'h100, 32'hB0);
        tx_ready = 1'b0;
        rdq(32'h104, 32'h802, "status_push_pop_full");
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("tx_drain2", 32'(exp_tx.size()), 32'h0);
        rdq(32'h104, 32'h1, "status_empty2");

        wr(32'h108, 32'hFFFF_FFFE);
        rdq(32'h108, 32'hFFFF_FFFE, "timer_load");
        rdq(32'h108, 32'hFFFF_FFFF, "timer_inc");
        rdq(32'h108, 32'h0000_0000, "timer_wrap");

        wr(32'h200, 32'h1234);
        check("bus_err_set", {31'b0, bus_err}, 32'h1);
        rdq(32'h200, 32'h0, "unmapped_read");
        rdq(32'h64, 32'd7, "ram_after_berr");
        check("gpo_after_berr", gpo, 32'h5A5A);
        wr(32'h10C, 32'h77);
        check("bus_err_sticky", {31'b0, bus_err}, 32'h1);
        check("gpo_write", gpo, 32'h77);

        // Reset mid-stream with a same-cycle push: everything discarded.
        for (int i = 0; i < 3; i++) wr(32'h100, 32'hD0 + 32'(i));
        check("tx_valid_pre_reset", {31'b0, tx_valid}, 32'h1);
        reset = 1'b1; we = 1'b1; a = 32'h100; wd = 32'hEE;
        @(posedge clk); #1;
        reset = 1'b0; we = 1'b0;
        rdq(32'h108, 32'h0, "timer_after_reset2");
        check("tx_valid_reset2", {31'b0, tx_valid}, 32'h0);
        rdq(32'h104, 32'h1, "status_reset2");
        rdq(32'h64, 32'd7, "ram_preserved");
        check("bus_err_reset2", {31'b0, bus_err}, 32'h0);
        check("gpo_reset2", gpo, 32'h0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
